// File: rtl/seg_scan_driver.sv
// Multiplexed hex display scanner with frame-synchronous loading, leading-zero
// suppression and per-digit blinking. All outputs are registered.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);
  localparam logic [FrmW-1:0] FrmMax = FrmW'(BLINK_FRAMES - 1);

  logic [DivW-1:0]         div_q;
  logic [IdxW-1:0]         idx_q;
  logic [FrmW-1:0]         frm_q;
  logic                    blink_q;
  logic [4*NUM_DIGITS-1:0] act_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q, act_blink_q, pend_blink_q;
  logic                    pend_valid_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  logic                    boundary;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    all_zero;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    unique case (h)
      4'h0: hex7 = 7'h7E;
      4'h1: hex7 = 7'h30;
      4'h2: hex7 = 7'h6D;
      4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;
      4'h5: hex7 = 7'h5B;
      4'h6: hex7 = 7'h5F;
      4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h7B;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;
      4'hD: hex7 = 7'h3D;
      4'hE: hex7 = 7'h4F;
      default: hex7 = 7'h47;
    endcase
  endfunction

  assign boundary = (div_q == DivMax) && (idx_q == IdxMax);

  always_comb begin
    nib       = act_val_q[4*idx_q +: 4];
    zero_from = '0;
    all_zero  = 1'b1;
    // zero_from[k]: nibbles k..top are all zero
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (act_val_q[4*k +: 4] == 4'h0);
      zero_from[k] = all_zero;
    end
    seg_d    = hex7(nib);
    dp_out_d = act_dp_q[idx_q];
    if (blink_q && act_blink_q[idx_q]) begin
      seg_d    = 7'h00;
      dp_out_d = 1'b0;
    end else if (lz_en && (idx_q != '0) && zero_from[idx_q]) begin
      seg_d = 7'h00;
    end
    an_d        = '0;
    an_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      blink_q      <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= '0;
      dp_out_q     <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
      if (load) begin
        pend_val_q   <= value;
        pend_dp_q    <= dp;
        pend_blink_q <= blink_en;
        pend_valid_q <= 1'b1;
      end
      if (div_q == DivMax) begin
        div_q <= '0;
        idx_q <= (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (boundary) begin
        // A load on the boundary itself goes straight to the active set
        if (load) begin
          act_val_q   <= value;
          act_dp_q    <= dp;
          act_blink_q <= blink_en;
        end else if (pend_valid_q) begin
          act_val_q   <= pend_val_q;
          act_dp_q    <= pend_dp_q;
          act_blink_q <= pend_blink_q;
        end
        pend_valid_q <= 1'b0;
        if (frm_q == FrmMax) begin
          frm_q   <= '0;
          blink_q <= ~blink_q;
        end else begin
          frm_q <= frm_q + 1'b1;
        end
      end
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_out_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-level reference model feeding a scoreboard,
// plus a decode/suppression vector table checked digit by digit.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FL = SD * ND;

  logic        clk = 1'b0;
  logic        rst, load, lz_en;
  logic [15:0] value;
  logic [3:0]  dp, blink_en;
  logic [6:0]  seg;
  logic        dp_out, frame_done;
  logic [3:0]  an;

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .blink_en   (blink_en),
    .lz_en      (lz_en),
    .seg        (seg),
    .dp_out     (dp_out),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } out_t;

  typedef struct packed {
    logic [15:0]     v;
    logic            lz;
    logic [3:0][6:0] s;  // s[k] = expected seg of digit k
  } vec_t;

  out_t        exp_q[$];
  vec_t        tbl[9];
  logic [6:0]  hex_tab[16];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  // reference model state
  int          m_t;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp, m_bl, m_pbl;
  logic        m_pv;

  logic [15:0] cur_v;
  logic [3:0]  cur_d, cur_b;
  logic        cur_lz;
  logic [6:0]  obs_seg;
  logic [3:0]  obs_an;
  logic        obs_fd;

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b, input logic lz);
    out_t       e, g;
    int         k;
    logic       blank, sup;
    @(negedge clk);
    rst = r; load = ld; value = v; dp = d; blink_en = b; lz_en = lz;
    if (r) begin
      e = '0;
      m_t = 0; m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0;
      m_bl = '0; m_pbl = '0; m_pv = 1'b0;
    end else begin
      k     = (m_t / SD) % ND;
      blank = (((m_t / FL) / BF) % 2 == 1) && m_bl[k];
      sup   = lz && (k > 0) && ((m_val >> (4 * k)) == 16'h0);
      e.seg = (blank || sup) ? 7'h00 : hex_tab[m_val[4*k +: 4]];
      e.dp  = blank ? 1'b0 : m_dp[k];
      e.an  = 4'b0001 << k;
      e.fd  = (m_t % FL) == FL - 1;
      if (e.fd) begin
        if (ld) begin
          m_val = v; m_dp = d; m_bl = b;
        end else if (m_pv) begin
          m_val = m_pval; m_dp = m_pdp; m_bl = m_pbl;
        end
        m_pv = 1'b0;
      end else if (ld) begin
        m_pval = v; m_pdp = d; m_pbl = b; m_pv = 1'b1;
      end
      m_t++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    g = {seg, dp_out, an, frame_done};
    e = exp_q.pop_front();
    total++;
    if (g !== e)
      begin
        bad++;
        $display("FAIL outputs cycle %0d: got seg=%h dp=%b an=%b fd=%b, want seg=%h dp=%b an=%b fd=%b",
                 cyc, g.seg, g.dp, g.an, g.fd, e.seg, e.dp, e.an, e.fd);
      end
    obs_seg = seg; obs_an = an; obs_fd = frame_done;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, cur_v, cur_d, cur_b, cur_lz);
  endtask

  task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    cur_v = v; cur_d = d; cur_b = b;
    step(1'b0, 1'b1, v, d, b, cur_lz);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 3 * FL; i++) begin
      idle(1);
      if (obs_fd) return;
    end
    total++; bad++;
    $display("FAIL frame_done timeout: got none, want pulse within %0d cycles", 3 * FL);
  endtask

  task automatic check_vec(input int i);
    int k;
    wait_fd();
    for (int c = 0; c < FL; c++) begin
      idle(1);
      k = -1;
      for (int j = 0; j < ND; j++) if (obs_an == (4'b0001 << j)) k = j;
      total++;
      if (k < 0 || obs_seg !== tbl[i].s[k]) begin
        bad++;
        $display("FAIL table[%0d] digit %0d: got seg=%h an=%b, want seg=%h",
                 i, k, obs_seg, obs_an, (k < 0) ? 7'h00 : tbl[i].s[k < 0 ? 0 : k]);
      end
    end
  endtask

  initial begin
    hex_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    tbl[0] = '{16'h1A3F, 1'b0, {7'h30, 7'h77, 7'h79, 7'h47}};
    tbl[1] = '{16'h0005, 1'b1, {7'h00, 7'h00, 7'h00, 7'h5B}};
    tbl[2] = '{16'h0100, 1'b1, {7'h00, 7'h30, 7'h7E, 7'h7E}};
    tbl[3] = '{16'h0100, 1'b0, {7'h7E, 7'h30, 7'h7E, 7'h7E}};
    tbl[4] = '{16'h2222, 1'b0, {7'h6D, 7'h6D, 7'h6D, 7'h6D}};
    tbl[5] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
    tbl[6] = '{16'hBCDE, 1'b1, {7'h1F, 7'h4E, 7'h3D, 7'h4F}};
    tbl[7] = '{16'h6789, 1'b0, {7'h5F, 7'h70, 7'h7F, 7'h7B}};
    tbl[8] = '{16'h4050, 1'b1, {7'h33, 7'h7E, 7'h5B, 7'h7E}};

    rst = 1'b1; load = 1'b0; value = '0; dp = '0; blink_en = '0; lz_en = 1'b0;
    cur_v = '0; cur_d = '0; cur_b = '0; cur_lz = 1'b0;
    obs_seg = '0; obs_an = '0; obs_fd = 1'b0;

    // reset, with a load in the same cycle that must be ignored
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0, 1'b0);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(3 * FL);

    // decode and leading-zero table
    for (int i = 0; i < 9; i++) begin
      cur_lz = tbl[i].lz;
      idle(3);
      ld(tbl[i].v, 4'h0, 4'h0);
      check_vec(i);
    end
    cur_lz = 1'b0;

    // two loads in one frame: last wins
    idle(2);
    ld(16'h1111, 4'h0, 4'h0);
    idle(2);
    ld(16'h2222, 4'h0, 4'h0);
    idle(FL + 4);

    // load on the boundary cycle takes effect in the very next frame
    for (int i = 0; i < FL && (m_t % FL) != FL - 1; i++) idle(1);
    ld(16'h3333, 4'h0, 4'h0);
    idle(FL + 2);

    // blink on digit 1 with its decimal point lit
    ld(16'h8888, 4'b0010, 4'b0010);
    idle(6 * FL);

    // reset mid-frame with a pending load that must never appear
    idle(5);
    ld(16'hFFFF, 4'hF, 4'h0);
    idle(2);
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b0);
    cur_v = 16'hFFFF; cur_d = 4'hF;
    idle(3 * FL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4; number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000; clock cycles per digit slot, legal range >= 2.
REQ-003 Parameter BLINK_FRAMES, default 256; complete scan frames per blink half-period, legal range >= 1.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous to clk, active-high.
REQ-006 load  in  1  capture request for value/dp/blink_en.
REQ-007 value  in  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k]; digit 0 least significant.
REQ-008 dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 blink_en  in  NUM_DIGITS  per-digit blink enable.
REQ-010 lz_en  in  1  leading-zero suppression enable, sampled live (not captured by load).
REQ-011 seg  out  7  segments {a,b,c,d,e,f,g}, a = bit 6, 1 = lit.
REQ-012 dp_out  out  1  decimal point of the displayed digit, 1 = lit.
REQ-013 an  out  NUM_DIGITS  one-hot digit enable, bit k = digit k, 1 = enabled.
REQ-014 frame_done  out  1  single-cycle pulse at frame boundary.

Function
REQ-015 Divider div counts 0..SCAN_DIV-1 and wraps to 0; on wrap, digit index idx increments, wrapping NUM_DIGITS-1 -> 0.
REQ-016 Frame boundary cycle: div == SCAN_DIV-1 and idx == NUM_DIGITS-1; frame_done = 1 on the following cycle only.
REQ-017 All outputs registered; seg/dp_out/an reflect the idx value held during the previous cycle, so an and seg always change on the same edge.
REQ-018 load = 1 writes value/dp/blink_en into a pending register and sets pending_valid; multiple loads before a boundary: last one wins.
REQ-019 At a boundary cycle, the active register takes the inputs if load = 1 that cycle, else the pending contents if pending_valid = 1, else holds; pending_valid then clears; no tearing within a frame.
REQ-020 Hex decode (seg, hex): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47.
REQ-021 Leading-zero suppression: with lz_en = 1, digit k > 0 shows seg = 00 when active nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never suppressed; dp_out is unaffected.
REQ-022 Blink: frame counter counts boundaries; after BLINK_FRAMES boundaries it clears and blink phase toggles; phase = 1 forces seg = 00 and dp_out = 0 for digits whose active blink_en bit = 1; an is unaffected.
REQ-023 Blink has priority over suppression; both act only on seg/dp_out, never on an.

Reset
REQ-024 rst = 1 at an edge: seg = 00, dp_out = 0, an = 0, frame_done = 0; div, idx, frame counter, blink phase, active, pending and pending_valid all cleared.
REQ-025 First edge with rst = 0: an = one-hot digit 0, seg = 7E (active value 0), div starts at 0.
REQ-026 rst mid-frame or with pending load: pending data is discarded; load in the same cycle as rst is ignored.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 Release reset, no load -> an = 0001,0010,0100,1000 for 4 cycles each, repeating; seg = 7E throughout; frame_done pulses every 16 cycles.
REQ-028 Mid-frame load value=16'h1A3F -> display unchanged until the boundary; next frame: digit0 = 47, digit1 = 79, digit2 = 77, digit3 = 30.
REQ-029 lz_en=1, value=16'h0005 -> digits 3,2,1 seg = 00, digit0 = 5B; value=16'h0100 -> digit3 = 00, digit2 = 30, digit1 = 7E, digit0 = 7E.
REQ-030 blink_en=4'b0010, dp=4'b0010, value=16'h8888 -> digit1 shows seg = 7F, dp_out = 1 in frames 0-1 and seg = 00, dp_out = 0 in frames 2-3; other digits always 7F.
REQ-031 Load 16'h1111 then 16'h2222 in the same frame -> next frame shows 6D on all digits; load 16'h3333 on the boundary cycle itself -> 79 from the immediately following frame.
REQ-032 Assert rst mid-frame with pending load 16'hFFFF -> outputs 0 while rst = 1; after release seg = 7E and pending data is never displayed.
